// File: rtl/chess_game_ctrl.sv
// Chess clock game controller: button conditioning, time select and game FSM.
// Drives the countDown block (enable/player/timeIn) and reports state/winner.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   btn_start  raw start/pause button
//   btn_mode   raw time-select button
//   btn_p1     raw player-1 clock button
//   btn_p2     raw player-2 clock button
//   min1/sec1  remaining time of player 1 (binary)
//   min2/sec2  remaining time of player 2 (binary)
//   enable     countdown enable
//   player     00 hold, 01 run 1, 10 run 2, 11 reload both
//   timeIn     selected game length in minutes
//   winner     00 none, 01 player 1, 10 player 2
//   state      FSM state code

// One button: 2-FF synchronizer, debouncer, rising-edge pulse.
// Ports: clk, reset, raw (async button), pulse (one cycle per press).
module chess_btn_cond #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES + 2);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(DEB_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic          prev;
  logic          armed;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] arm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive
  // cycles of disagreement with the current level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= 1'b0;
      deb_cnt <= '0;
    end else if (sync == level) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_LAST) begin
      level   <= sync;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + CW'(1);
    end
  end

  // After reset the button must be seen released long enough
  // (synchronizer flush plus a full debounce window) before
  // presses count; a button held through reset gives no pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      arm_cnt <= '0;
    end else if (!armed) begin
      if (sync) begin
        arm_cnt <= '0;
      end else if (arm_cnt == ARM_LAST) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign pulse = armed & level & ~prev;

endmodule

module chess_game_ctrl #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic [7:0] min1,
  input  logic [7:0] sec1,
  input  logic [7:0] min2,
  input  logic [7:0] sec2,
  output logic       enable,
  output logic [1:0] player,
  output logic [7:0] timeIn,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    SETUP    = 3'd0,
    READY    = 3'd1,
    RUN_P1   = 3'd2,
    RUN_P2   = 3'd3,
    PAUSE    = 3'd4,
    GAMEOVER = 3'd5
  } state_t;

  localparam logic [1:0] PL_HOLD   = 2'b00;
  localparam logic [1:0] PL_RUN1   = 2'b01;
  localparam logic [1:0] PL_RUN2   = 2'b10;
  localparam logic [1:0] PL_RELOAD = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  logic start_p;
  logic mode_p;
  logic p1_p;
  logic p2_p;

  chess_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_start),
    .pulse (start_p)
  );

  chess_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_mode),
    .pulse (mode_p)
  );

  chess_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_p1 (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_p1),
    .pulse (p1_p)
  );

  chess_btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_p2 (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_p2),
    .pulse (p2_p)
  );

  state_t     state_q;
  state_t     state_d;
  logic [2:0] idx_q;
  logic [2:0] idx_d;
  logic       resume_p2_q;
  logic       resume_p2_d;
  logic [1:0] winner_d;
  logic       en_d;
  logic [1:0] pl_d;
  logic       out1;
  logic       out2;

  assign out1 = (min1 == 8'd0) && (sec1 == 8'd0);
  assign out2 = (min2 == 8'd0) && (sec2 == 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SETUP;
      idx_q       <= 3'd2;
      resume_p2_q <= 1'b0;
      winner      <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      resume_p2_q <= resume_p2_d;
      winner      <= winner_d;
    end
  end

  // Priority within a cycle: timeout, start, mode, player.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    resume_p2_d = resume_p2_q;
    winner_d    = winner;
    unique case (state_q)
      SETUP: begin
        if (start_p) begin
          state_d = READY;
        end else if (mode_p) begin
          idx_d = (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
      end
      READY: begin
        if (start_p) begin
          state_d = RUN_P1;
        end else if (mode_p) begin
          state_d = SETUP;
        end
      end
      RUN_P1: begin
        if (out1) begin
          state_d  = GAMEOVER;
          winner_d = WIN_P2;
        end else if (start_p) begin
          state_d     = PAUSE;
          resume_p2_d = 1'b0;
        end else if (p1_p) begin
          state_d = RUN_P2;
        end
      end
      RUN_P2: begin
        if (out2) begin
          state_d  = GAMEOVER;
          winner_d = WIN_P1;
        end else if (start_p) begin
          state_d     = PAUSE;
          resume_p2_d = 1'b1;
        end else if (p2_p) begin
          state_d = RUN_P1;
        end
      end
      PAUSE: begin
        if (start_p) begin
          state_d = resume_p2_q ? RUN_P2 : RUN_P1;
        end else if (mode_p) begin
          state_d = SETUP;
        end
      end
      GAMEOVER: begin
        if (start_p) begin
          state_d  = SETUP;
          winner_d = WIN_NONE;
        end
      end
      default: begin
        state_d  = SETUP;
        winner_d = WIN_NONE;
      end
    endcase
  end

  // Decode from the next state so the registered outputs
  // change on the same edge as the state register.
  always_comb begin
    en_d = 1'b0;
    pl_d = PL_HOLD;
    unique case (state_d)
      SETUP:    pl_d = PL_RELOAD;
      RUN_P1: begin
        en_d = 1'b1;
        pl_d = PL_RUN1;
      end
      RUN_P2: begin
        en_d = 1'b1;
        pl_d = PL_RUN2;
      end
      default: begin
        en_d = 1'b0;
        pl_d = PL_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= 1'b0;
      player <= PL_RELOAD;
    end else begin
      enable <= en_d;
      player <= pl_d;
    end
  end

  always_comb begin
    unique case (idx_q)
      3'd0:    timeIn = 8'd1;
      3'd1:    timeIn = 8'd3;
      3'd2:    timeIn = 8'd5;
      3'd3:    timeIn = 8'd10;
      3'd4:    timeIn = 8'd15;
      3'd5:    timeIn = 8'd30;
      default: timeIn = 8'd5;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_chess_game_ctrl.sv
// Directed bench for chess_game_ctrl with a small debounce window.
// Expected outputs are queued per step and compared once the step settles.
module tb_chess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [7:0] min1;
  logic [7:0] sec1;
  logic [7:0] min2;
  logic [7:0] sec2;
  logic       enable;
  logic [1:0] player;
  logic [7:0] timeIn;
  logic [1:0] winner;
  logic [2:0] state;

  localparam int B_START = 0;
  localparam int B_MODE  = 1;
  localparam int B_P1    = 2;
  localparam int B_P2    = 3;

  always #5 clk = ~clk;

  chess_game_ctrl #(.DEB_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn[0]),
    .btn_mode  (btn[1]),
    .btn_p1    (btn[2]),
    .btn_p2    (btn[3]),
    .min1      (min1),
    .sec1      (sec1),
    .min2      (min2),
    .sec2      (sec2),
    .enable    (enable),
    .player    (player),
    .timeIn    (timeIn),
    .winner    (winner),
    .state     (state)
  );

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       en;
    logic [1:0] pl;
    logic [1:0] win;
    logic [7:0] tin;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_exp(input string tag, input logic [2:0] st,
                          input logic en, input logic [1:0] pl,
                          input logic [1:0] win, input logic [7:0] tin);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.en  = en;
    e.pl  = pl;
    e.win = win;
    e.tin = tin;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input string f,
                     input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, f, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: no expected entry queued");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "state", {5'd0, state}, {5'd0, e.st});
      cmp(e.tag, "enable", {7'd0, enable}, {7'd0, e.en});
      cmp(e.tag, "player", {6'd0, player}, {6'd0, e.pl});
      cmp(e.tag, "winner", {6'd0, winner}, {6'd0, e.win});
      cmp(e.tag, "timeIn", timeIn, e.tin);
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (8) @(posedge clk);
    #1 btn[b] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic act(input int b, input string tag, input logic [2:0] st,
                     input logic en, input logic [1:0] pl,
                     input logic [1:0] win, input logic [7:0] tin);
    push_exp(tag, st, en, pl, win, tin);
    press(b);
    check_out();
  endtask

  initial begin
    reset = 1'b1;
    btn   = 4'd0;
    min1  = 8'd5;
    sec1  = 8'd0;
    min2  = 8'd5;
    sec2  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);
    check_out();
    @(negedge clk) reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    act(B_MODE, "mode1", 3'd0, 1'b0, 2'b11, 2'b00, 8'd10);
    act(B_MODE, "mode2", 3'd0, 1'b0, 2'b11, 2'b00, 8'd15);
    act(B_MODE, "mode3", 3'd0, 1'b0, 2'b11, 2'b00, 8'd30);
    act(B_MODE, "mode_wrap", 3'd0, 1'b0, 2'b11, 2'b00, 8'd1);
    act(B_MODE, "mode5", 3'd0, 1'b0, 2'b11, 2'b00, 8'd3);
    act(B_MODE, "mode6", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);

    push_exp("glitch", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);
    btn[B_START] = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn[B_START] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_out();

    act(B_START, "ready", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_MODE, "ready_mode", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);
    act(B_START, "ready2", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);

    push_exp("ready_zero", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);
    min1 = 8'd0;
    sec1 = 8'd0;
    repeat (10) @(posedge clk);
    #1;
    check_out();
    min1 = 8'd5;

    act(B_P1, "ready_p1", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_START, "run_p1", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);
    act(B_P2, "p1_ign_p2", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);
    act(B_MODE, "run_mode", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);
    act(B_P1, "run_p2", 3'd3, 1'b1, 2'b10, 2'b00, 8'd5);
    act(B_P1, "p2_ign_p1", 3'd3, 1'b1, 2'b10, 2'b00, 8'd5);
    act(B_START, "pause_p2", 3'd4, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_START, "resume_p2", 3'd3, 1'b1, 2'b10, 2'b00, 8'd5);
    act(B_P2, "back_p1", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);
    act(B_START, "pause_p1", 3'd4, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_START, "resume_p1", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);

    // Timeout lands on the same edge as the p1 pulse.
    push_exp("timeout_p1", 3'd5, 1'b0, 2'b00, 2'b10, 8'd5);
    btn[B_P1] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    min1 = 8'd0;
    sec1 = 8'd0;
    repeat (2) @(posedge clk);
    #1 btn[B_P1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_out();
    min1 = 8'd5;

    act(B_P1, "over_hold", 3'd5, 1'b0, 2'b00, 2'b10, 8'd5);
    act(B_START, "over_setup", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);

    act(B_START, "g2_ready", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_START, "g2_p1", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);
    act(B_P1, "g2_p2", 3'd3, 1'b1, 2'b10, 2'b00, 8'd5);
    push_exp("timeout_p2", 3'd5, 1'b0, 2'b00, 2'b01, 8'd5);
    min2 = 8'd0;
    sec2 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_out();
    min2 = 8'd5;
    act(B_START, "g2_setup", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);

    act(B_START, "g3_ready", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_START, "g3_p1", 3'd2, 1'b1, 2'b01, 2'b00, 8'd5);
    act(B_START, "g3_pause", 3'd4, 1'b0, 2'b00, 2'b00, 8'd5);
    act(B_MODE, "g3_abort", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);
    act(B_MODE, "g3_sel10", 3'd0, 1'b0, 2'b11, 2'b00, 8'd10);

    act(B_START, "g4_ready", 3'd1, 1'b0, 2'b00, 2'b00, 8'd10);
    act(B_START, "g4_p1", 3'd2, 1'b1, 2'b01, 2'b00, 8'd10);
    act(B_P1, "g4_p2", 3'd3, 1'b1, 2'b10, 2'b00, 8'd10);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    push_exp("async_rst", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);
    check_out();

    // Start held through reset release must not start the game.
    btn[B_START] = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    push_exp("held_rst", 3'd0, 1'b0, 2'b11, 2'b00, 8'd5);
    repeat (20) @(posedge clk);
    #1;
    check_out();
    btn[B_START] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    act(B_START, "repress", 3'd1, 1'b0, 2'b00, 2'b00, 8'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
